// File: rtl/fifo_ptr_wrap.sv
// Wrapping FIFO pointer: low bits count 0..Depth-1, top bit toggles on wrap.
// Ports: clk_i, rst_ni (async, active-low), clr_i (sync clear), inc_i, ptr_o.
module fifo_ptr_wrap #(
    parameter int unsigned Depth = 4,
    parameter int unsigned PtrW  = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PtrW:0] ptr_o
);

    localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

    logic [PtrW:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            if (ptr_q[PtrW-1:0] == LastIdx) begin
                ptr_d = {~ptr_q[PtrW], {PtrW{1'b0}}};
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_flex.sv
// Synchronous FIFO with optional fall-through, flush and watermarks.
// Ports: clk_i, rst_ni, clr_i, write (wvalid_i/wready_o/wdata_i), read
// (rvalid_o/rready_i/rdata_o), depth_o, thresholds, almost_full_o/almost_empty_o.
module fifo_sync_flex #(
    parameter int unsigned Width             = 16,
    parameter int unsigned Depth             = 4,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    // At least one bit so the count ports stay legal when Depth=0.
    localparam int unsigned DepthW = (Depth == 0) ? 1 : $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o,
    input  logic [DepthW-1:0] afull_thresh_i,
    input  logic [DepthW-1:0] aempty_thresh_i,
    output logic              almost_full_o,
    output logic              almost_empty_o
);

    if (Depth == 0) begin : g_wire
        logic unused_wire;
        assign unused_wire = ^{clk_i, rst_ni, clr_i};
        assign wready_o = rready_i;
        assign rvalid_o = wvalid_i;
        assign rdata_o  = wdata_i;
        assign depth_o  = '0;
    end else begin : g_fifo
        localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

        logic [PtrW:0]      wptr, rptr;
        logic               full, empty, pass_thru;
        logic               push, pop, wr_en, rd_en;
        logic [Width-1:0]   mem_q [Depth];

        assign empty = (wptr == rptr);
        assign full  = (wptr[PtrW-1:0] == rptr[PtrW-1:0]) &&
                       (wptr[PtrW] != rptr[PtrW]);

        assign pass_thru = Pass && empty;
        assign wready_o  = !full && !clr_i;
        assign rvalid_o  = (!empty || (Pass && wvalid_i)) && !clr_i;
        assign push      = wvalid_i && wready_o;
        assign pop       = rvalid_o && rready_i;

        // A fall-through word consumed in the same cycle never touches storage.
        assign wr_en = push && !(pass_thru && pop);
        assign rd_en = pop && !pass_thru;

        fifo_ptr_wrap #(.Depth(Depth), .PtrW(PtrW)) u_wptr (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .clr_i (clr_i),
            .inc_i (wr_en),
            .ptr_o (wptr)
        );

        fifo_ptr_wrap #(.Depth(Depth), .PtrW(PtrW)) u_rptr (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .clr_i (clr_i),
            .inc_i (rd_en),
            .ptr_o (rptr)
        );

        // Storage is deliberately left unreset; the pointers define validity.
        always_ff @(posedge clk_i) begin
            if (wr_en) begin
                mem_q[wptr[PtrW-1:0]] <= wdata_i;
            end
        end

        always_comb begin
            if (full) begin
                depth_o = DepthW'(Depth);
            end else if (wptr[PtrW] == rptr[PtrW]) begin
                depth_o = DepthW'(wptr[PtrW-1:0]) - DepthW'(rptr[PtrW-1:0]);
            end else begin
                depth_o = DepthW'(Depth) - DepthW'(rptr[PtrW-1:0])
                        + DepthW'(wptr[PtrW-1:0]);
            end
        end

        always_comb begin
            rdata_o = mem_q[rptr[PtrW-1:0]];
            if (pass_thru) begin
                rdata_o = wdata_i;
            end
            if (OutputZeroIfEmpty && !rvalid_o) begin
                rdata_o = '0;
            end
        end
    end

    assign almost_full_o  = (depth_o >= afull_thresh_i);
    assign almost_empty_o = (depth_o <= aempty_thresh_i);

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: four configurations share one stimulus stream
// and are compared against queue-based reference models every cycle.
module tb_fifo_sync_flex;

    logic        clk = 1'b0;
    logic        rst_n, clr, wvalid, rready;
    logic [15:0] wdata;
    logic [2:0]  th_af, th_ae;

    always #5 clk = ~clk;

    // index 0: Depth3 Pass0, 1: Depth3 Pass1, 2: Depth5 Pass1, 3: Depth0
    logic [3:0]       wr, rv, af, ae;
    logic [3:0][15:0] rd;
    logic [3:0][2:0]  dp;
    logic [1:0]       dp_a, dp_b;
    logic [2:0]       dp_c;
    logic [0:0]       dp_d;

    always_comb begin
        dp[0] = {1'b0, dp_a};
        dp[1] = {1'b0, dp_b};
        dp[2] = dp_c;
        dp[3] = {2'b00, dp_d};
    end

    fifo_sync_flex #(.Width(16), .Depth(3), .Pass(1'b0)) u_d3p0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wr[0]), .wdata_i(wdata),
        .rvalid_o(rv[0]), .rready_i(rready), .rdata_o(rd[0]),
        .depth_o(dp_a), .afull_thresh_i(th_af[1:0]),
        .aempty_thresh_i(th_ae[1:0]),
        .almost_full_o(af[0]), .almost_empty_o(ae[0])
    );

    fifo_sync_flex #(.Width(16), .Depth(3), .Pass(1'b1)) u_d3p1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wr[1]), .wdata_i(wdata),
        .rvalid_o(rv[1]), .rready_i(rready), .rdata_o(rd[1]),
        .depth_o(dp_b), .afull_thresh_i(th_af[1:0]),
        .aempty_thresh_i(th_ae[1:0]),
        .almost_full_o(af[1]), .almost_empty_o(ae[1])
    );

    fifo_sync_flex #(.Width(16), .Depth(5), .Pass(1'b1)) u_d5p1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wr[2]), .wdata_i(wdata),
        .rvalid_o(rv[2]), .rready_i(rready), .rdata_o(rd[2]),
        .depth_o(dp_c), .afull_thresh_i(th_af),
        .aempty_thresh_i(th_ae),
        .almost_full_o(af[2]), .almost_empty_o(ae[2])
    );

    fifo_sync_flex #(.Width(16), .Depth(0), .Pass(1'b1)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wr[3]), .wdata_i(wdata),
        .rvalid_o(rv[3]), .rready_i(rready), .rdata_o(rd[3]),
        .depth_o(dp_d), .afull_thresh_i(th_af[0:0]),
        .aempty_thresh_i(th_ae[0:0]),
        .almost_full_o(af[3]), .almost_empty_o(ae[3])
    );

    int          cap [4] = '{3, 3, 5, 0};
    bit          pas [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int          tw  [4] = '{2, 2, 3, 1};
    logic [15:0] q   [4][$];
    int          vecs = 0;
    int          errs = 0;

    function automatic logic [22:0] expect_out(int i);
        int          n   = q[i].size();
        int          msk = (1 << tw[i]) - 1;
        int          maf = int'(th_af) & msk;
        int          mae = int'(th_ae) & msk;
        logic        ew, ev;
        logic [15:0] ed;
        int          edp;
        if (cap[i] == 0) begin
            ew  = rready;
            ev  = wvalid;
            ed  = wdata;
            edp = 0;
        end else begin
            ew  = !clr && (n < cap[i]);
            ev  = !clr && (n > 0 || (pas[i] && wvalid));
            ed  = !ev ? 16'h0 : (n > 0 ? q[i][0] : wdata);
            edp = n;
        end
        return {ew, ev, ed, 3'(edp), (edp >= maf), (edp <= mae)};
    endfunction

    function automatic logic [22:0] got(int i);
        return {wr[i], rv[i], rd[i], dp[i], af[i], ae[i]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) q[i].delete();
    endtask

    task automatic advance();
        logic [22:0] e;
        logic        push, pop;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            e = expect_out(i);
            if (!rst_n) begin
                q[i].delete();
            end else if (cap[i] > 0) begin
                if (clr) begin
                    q[i].delete();
                end else begin
                    push = wvalid && e[22];
                    pop  = e[21] && rready;
                    if (!(q[i].size() == 0 && push && pop)) begin
                        if (pop) void'(q[i].pop_front());
                        if (push) q[i].push_back(wdata);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; wvalid = 1'b0; rready = 1'b0;
        wdata = 16'h0; th_af = 3'd0; th_ae = 3'd0;
        model_clear();
        #2;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (got(i) !== expect_out(i)) begin
                errs++;
                $display("FAIL reset dut%0d got %h want %h",
                         i, got(i), expect_out(i));
            end
        end
        vecs++;
        if ({wr[0], rv[0], dp[0], ae[0], af[0]} !== 7'b1_0_000_1_1) begin
            errs++;
            $display("FAIL reset_lit got %b want 1000011",
                     {wr[0], rv[0], dp[0], ae[0], af[0]});
        end
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [15:0] words [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        th_af = 3'd3; th_ae = 3'd0; rready = 1'b0; wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wdata = words[k];
            #2;
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (got(i) !== expect_out(i)) begin
                    errs++;
                    $display("FAIL fill dut%0d got %h want %h",
                             i, got(i), expect_out(i));
                end
            end
            advance();
        end
        wvalid = 1'b0;
        #2;
        vecs++;
        if ({wr[0], dp[0], af[0]} !== 5'b0_011_1) begin
            errs++;
            $display("FAIL full_lit got %b want 00111",
                     {wr[0], dp[0], af[0]});
        end
        rready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            vecs++;
            if (rd[0] !== words[k] || rv[0] !== 1'b1) begin
                errs++;
                $display("FAIL drain_order k%0d got %h want %h",
                         k, rd[0], words[k]);
            end
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (got(i) !== expect_out(i)) begin
                    errs++;
                    $display("FAIL drain dut%0d got %h want %h",
                             i, got(i), expect_out(i));
                end
            end
            advance();
        end
        #2;
        vecs++;
        if (dp[0] !== 3'd0) begin
            errs++;
            $display("FAIL drain_empty got %0d want 0", dp[0]);
        end
    endtask

    task automatic test_stream();
        rready = 1'b0; wvalid = 1'b1; wdata = 16'($urandom);
        advance();
        rready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wdata = 16'($urandom);
            #2;
            vecs++;
            if (dp[0] !== 3'd1) begin
                errs++;
                $display("FAIL stream_depth c%0d got %0d want 1", k, dp[0]);
            end
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (got(i) !== expect_out(i)) begin
                    errs++;
                    $display("FAIL stream dut%0d got %h want %h",
                             i, got(i), expect_out(i));
                end
            end
            advance();
        end
        wvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #2;
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (got(i) !== expect_out(i)) begin
                    errs++;
                    $display("FAIL stream_tail dut%0d got %h want %h",
                             i, got(i), expect_out(i));
                end
            end
            advance();
        end
    endtask

    task automatic test_pass();
        clr = 1'b1; wvalid = 1'b0; rready = 1'b0;
        advance();
        clr = 1'b0; wvalid = 1'b1; rready = 1'b1; wdata = 16'h1234;
        #2;
        vecs++;
        if (rd[1] !== 16'h1234 || rv[1] !== 1'b1) begin
            errs++;
            $display("FAIL pass_data got %h want 1234", rd[1]);
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (got(i) !== expect_out(i)) begin
                errs++;
                $display("FAIL pass dut%0d got %h want %h",
                         i, got(i), expect_out(i));
            end
        end
        advance();
        wvalid = 1'b0;
        #2;
        vecs++;
        if (dp[1] !== 3'd0) begin
            errs++;
            $display("FAIL pass_depth got %0d want 0", dp[1]);
        end
    endtask

    task automatic test_clear();
        model_clear();
        rready = 1'b0; wvalid = 1'b1;
        clr = 1'b1;
        advance();
        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wdata = 16'($urandom);
            advance();
        end
        clr = 1'b1; wvalid = 1'b1;
        #2;
        vecs++;
        if ({wr[2], rv[2], dp[2]} !== 5'b0_0_010) begin
            errs++;
            $display("FAIL clr_gate got %b want 00010",
                     {wr[2], rv[2], dp[2]});
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (got(i) !== expect_out(i)) begin
                errs++;
                $display("FAIL clear dut%0d got %h want %h",
                         i, got(i), expect_out(i));
            end
        end
        advance();
        clr = 1'b0; wvalid = 1'b0;
        #2;
        vecs++;
        if (dp[2] !== 3'd0) begin
            errs++;
            $display("FAIL clr_depth got %0d want 0", dp[2]);
        end
    endtask

    task automatic test_reset_mid();
        rready = 1'b0; wvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wdata = 16'($urandom);
            advance();
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        vecs++;
        if (dp[0] !== 3'd0 || rd[0] !== 16'h0) begin
            errs++;
            $display("FAIL rst_mid got depth %0d data %h want 0 0",
                     dp[0], rd[0]);
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (got(i) !== expect_out(i)) begin
                errs++;
                $display("FAIL rst_mid dut%0d got %h want %h",
                         i, got(i), expect_out(i));
            end
        end
        advance();
        rst_n = 1'b1; wvalid = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            clr    = ($urandom_range(0, 24) == 0);
            wvalid = ($urandom_range(0, 9) < 6);
            rready = ($urandom_range(0, 9) < 5);
            wdata  = 16'($urandom);
            th_af  = 3'($urandom_range(0, 7));
            th_ae  = 3'($urandom_range(0, 7));
            #2;
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (got(i) !== expect_out(i)) begin
                    errs++;
                    $display("FAIL random c%0d dut%0d got %h want %h",
                             k, i, got(i), expect_out(i));
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_pass();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
